// File: rtl/bicubic_line_feeder.sv
// rtl/bicubic_line_feeder.sv - three-line buffer feeding 4-row pixel columns to the bicubic core
module bicubic_line_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int COL_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] row0_out,
  output logic [DATA_WIDTH-1:0] row1_out,
  output logic [DATA_WIDTH-1:0] row2_out,
  output logic [DATA_WIDTH-1:0] row3_out,
  output logic                  shift_window,
  output logic [COL_W-1:0]      col_out,
  output logic                  eol_out,
  output logic                  lines_full
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  logic                  accept;
  logic                  wr_en;
  logic [COL_W-1:0]      c_eff;
  logic [1:0]            n_eff;
  logic [COL_W-1:0]      col_d, col_q;
  logic [1:0]            line_d, line_q;

  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb3_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, rd3_q;

  logic [DATA_WIDTH-1:0] pix_q;
  logic [COL_W-1:0]      col_out_q;
  logic [1:0]            sel_q;
  logic                  shift_q, eol_q, full_q;

  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;
  assign wr_en    = accept & ~rst;

  // sof restarts the frame on the very pixel that carries it
  assign c_eff = sof ? '0 : col_q;
  assign n_eff = sof ? 2'd0 : line_q;

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (accept) begin
      if (c_eff == LAST_COL) begin
        col_d  = '0;
        line_d = (n_eff == 2'd3) ? 2'd3 : n_eff + 2'd1;
      end else begin
        col_d  = c_eff + 1'b1;
        line_d = n_eff;
      end
    end
  end

  // Read-first line RAMs: each line shifts one buffer deeper as it is read out
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1_mem[c_eff] <= in_pixel;
      lb2_mem[c_eff] <= lb1_mem[c_eff];
      lb3_mem[c_eff] <= lb2_mem[c_eff];
      rd1_q          <= lb1_mem[c_eff];
      rd2_q          <= lb2_mem[c_eff];
      rd3_q          <= lb3_mem[c_eff];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      line_q    <= 2'd0;
      pix_q     <= '0;
      col_out_q <= '0;
      sel_q     <= 2'd0;
      shift_q   <= 1'b0;
      eol_q     <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      line_q  <= line_d;
      shift_q <= accept;
      eol_q   <= accept && (c_eff == LAST_COL);
      if (accept) begin
        pix_q     <= in_pixel;
        col_out_q <= c_eff;
        sel_q     <= n_eff;
        full_q    <= (n_eff == 2'd3);
      end
    end
  end

  // Rows not yet backed by a real line replicate the nearest received one;
  // with sel_q cleared at reset the rows all follow pix_q, which reads as zero.
  always_comb begin
    row3_out = pix_q;
    row2_out = pix_q;
    row1_out = pix_q;
    row0_out = pix_q;
    case (sel_q)
      2'd1: begin
        row2_out = rd1_q;
        row1_out = rd1_q;
        row0_out = rd1_q;
      end
      2'd2: begin
        row2_out = rd1_q;
        row1_out = rd2_q;
        row0_out = rd2_q;
      end
      2'd3: begin
        row2_out = rd1_q;
        row1_out = rd2_q;
        row0_out = rd3_q;
      end
      default: ;
    endcase
  end

  assign shift_window = shift_q;
  assign col_out      = col_out_q;
  assign eol_out      = eol_q;
  assign lines_full   = full_q;

endmodule

// File: doc/bicubic_line_feeder.md
Name: bicubic_line_feeder

Overview:
- Upstream feeder for the bicubic interpolation core.
- Accepts a raster-order pixel stream and buffers the three previous image lines.
- For each accepted pixel, emits one column of 4 vertically aligned pixels plus a one-cycle `shift_window` strobe, which drives the core's row inputs and window shift directly.
- Replicates the top border until three full lines have been received.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line; must be ≥ 2.
- COL_W, 10, column counter width; must satisfy 2^COL_W ≥ IMG_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sof  in  1  start of frame; qualified by in_valid && in_ready; marks the pixel at column 0, line 0.
- in_pixel  in  DATA_WIDTH  raster pixel.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  feeder can accept; equals ~stall.
- stall  in  1  downstream hold; while high, no pixel is accepted.
- row0_out  out  DATA_WIDTH  pixel from line L-3 (oldest).
- row1_out  out  DATA_WIDTH  pixel from line L-2.
- row2_out  out  DATA_WIDTH  pixel from line L-1.
- row3_out  out  DATA_WIDTH  pixel from current line L.
- shift_window  out  1  one-cycle strobe; row*_out are valid for this column.
- col_out  out  COL_W  column index of the emitted column.
- eol_out  out  1  high with shift_window when col_out == IMG_WIDTH-1.
- lines_full  out  1  ≥3 lines buffered this frame; no replication active.

Behaviour:
- Accept = in_valid && in_ready; in_ready = ~stall (combinational).
- Reset values:
  - All outputs 0, except in_ready, which follows stall.
  - Column counter 0; line count 0.
  - Line RAM contents undefined; never read before being written, because replication masks them.
- Storage: three line memories LB1, LB2, LB3, each IMG_WIDTH x DATA_WIDTH, synchronous read-first.
- On accept at column c, the following happen in the same cycle:
  - Read LB1[c], LB2[c], LB3[c] (old values).
  - Write LB1[c] ← in_pixel, LB2[c] ← old LB1[c], LB3[c] ← old LB2[c].
  - Register in_pixel, c, and the eol condition.
- Latency: exactly 1 cycle. The cycle after an accept:
  - shift_window = 1.
  - row3_out = accepted pixel; row2/row1/row0_out = old LB1/LB2/LB3[c].
  - col_out = c.
- With no accept, shift_window = 0 and all row outputs and col_out hold their values.
- Column counter:
  - Increments on accept.
  - At IMG_WIDTH-1, wraps to 0 and the line count increments, saturating at 3.
- Top-border replication. Select from line count n, sampled at accept:
  - n=0: row0 = row1 = row2 = row3 = in_pixel.
  - n=1: row0 = row1 = row2 = old LB1.
  - n=2: row0 = row1 = old LB2.
  - n=3: no replication; lines_full = 1.
- sof:
  - An accepted pixel with sof=1 forces column 0 and line count 0 before the selection above, so it is treated as n=0, c=0.
  - After that pixel, the column counter is 1.
  - sof mid-line abandons the partial line. The RAMs are not cleared, and replication hides stale data.
- Stall: an input held while stall=1 is not consumed. Registered outputs stay frozen; shift_window = 0.
- Simultaneous events:
  - rst has priority over accept and sof.
  - An accept in the cycle after reset is processed normally as n=0, c=0.
- Reset mid-line: counters clear; the next frame must begin with sof or at column 0 (counter is already 0).
- No arithmetic beyond counters. Data paths are pure DATA_WIDTH moves; no truncation.

Test Plan (IMG_WIDTH=4):
- Reset, then stream line0 = 10,11,12,13 with sof on the first pixel → 4 strobes; each column shows rows = (p,p,p,p), e.g. col 2 → 12,12,12,12; eol_out on col 3; lines_full = 0.
- Continue line1 = 20..23, line2 = 30..33 → line1 col1 emits (11,11,11,21); line2 col3 emits (13,13,23,33).
- Line3 = 40..43 → col0 emits (10,20,30,40); lines_full = 1. Line4 = 50..53 → col2 emits (22,32,42,52).
- Stall for 3 cycles mid-line with in_valid high → in_ready = 0, shift_window = 0, outputs frozen; the next pixel after release continues at the correct column with no loss or duplication.
- sof asserted at column 2 of line 4 with pixel 99 → next strobe emits (99,99,99,99), col_out = 0; lines_full drops to 0.
- rst during line 3 col 1, then restart → first strobe after reset has col_out = 0 and full replication; shift_window is never asserted during reset.
